// File: rtl/banked_memory_arbiter_cluster.sv
// banked_memory_arbiter_cluster: multi-port banked memory with per-bank round-robin arbitration
module banked_memory_arbiter_cluster #(
  parameter int NUM_PORTS  = 3,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 2,
  parameter int INTERLEAVE = 0,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        halt,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_wen,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0] rsp_data,
  output logic [NUM_PORTS*TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]            conflict_cnt,
  input  logic                        cnt_clear
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int LW = ADDR_W - BW;
  localparam int PW = $clog2(NUM_PORTS);
  localparam int WORDS = 1 << ADDR_W;
  logic [BW-1:0]               bank_sel [NUM_PORTS];
  logic [LW-1:0]               loc_sel  [NUM_PORTS];
  logic [NUM_PORTS-1:0]        granted, xfer;
  logic [PW-1:0]               ptr_q [NUM_BANKS];
  logic [PW-1:0]               ptr_d [NUM_BANKS];
  logic [NUM_PORTS-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_PORTS*TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        contend;
  logic [DATA_W-1:0]           mem [WORDS];
  // split each port address into bank select and bank-local word address
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_sel[p] = (INTERLEAVE != 0) ? req_addr[p*ADDR_W +: BW] : req_addr[p*ADDR_W + ADDR_W - BW +: BW];
      loc_sel[p]  = (INTERLEAVE != 0) ? req_addr[p*ADDR_W + BW +: LW] : req_addr[p*ADDR_W +: LW];
    end
  end
  // per-bank round robin: lowest candidate at/after the pointer, else lowest candidate overall
  always_comb begin
    logic [PW-1:0] hi_sel, lo_sel, sel;
    logic          hi_f, lo_f;
    granted = '0;
    hi_sel = '0;
    lo_sel = '0;
    sel = '0;
    hi_f = 1'b0;
    lo_f = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ptr_d[b] = ptr_q[b];
      hi_f = 1'b0;
      lo_f = 1'b0;
      hi_sel = '0;
      lo_sel = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (req_valid[p] && bank_sel[p] == BW'(b)) begin
          if (PW'(p) >= ptr_q[b]) begin
            hi_sel = PW'(p);
            hi_f = 1'b1;
          end
          lo_sel = PW'(p);
          lo_f = 1'b1;
        end
      end
      sel = hi_f ? hi_sel : lo_sel;
      if (lo_f) begin
        granted[sel] = 1'b1;
        if (!halt) ptr_d[b] = (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
      end
    end
  end
  assign req_ready = halt ? '0 : granted;
  assign xfer = req_valid & req_ready;
  assign contend = |(req_valid & ~granted);
  // response capture, held while halted; write acks return zero data
  always_comb begin
    rsp_valid_d = halt ? rsp_valid_q : xfer;
    rsp_data_d = rsp_data_q;
    rsp_tag_d = rsp_tag_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (xfer[p]) begin
        rsp_data_d[p*DATA_W +: DATA_W] = req_wen[p] ? '0 : mem[{bank_sel[p], loc_sel[p]}];
        rsp_tag_d[p*TAG_W +: TAG_W] = req_tag[p*TAG_W +: TAG_W];
      end
    end
  end
  // contention counter: frozen by halt, clear beats increment, saturates at all-ones
  always_comb cnt_d = halt ? cnt_q : cnt_clear ? '0 : (contend && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      rsp_tag_q <= '0;
      cnt_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q <= rsp_tag_d;
      cnt_q <= cnt_d;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
    end
  end
  // bank storage; granted ports in one cycle always hit distinct banks
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (xfer[p] && req_wen[p]) mem[{bank_sel[p], loc_sel[p]}] <= req_data[p*DATA_W +: DATA_W];
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_tag = rsp_tag_q;
  assign conflict_cnt = cnt_q;
endmodule
